// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: operand forwarding, load-use/branch
// stalls, and the mult/div sequencer that strobes HI/LO and holds dependent instructions.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CW          = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rsd,
    input  logic [4:0] rtd,
    input  logic [4:0] rse,
    input  logic [4:0] rte,
    input  logic [4:0] writerege,
    input  logic [4:0] writeregm,
    input  logic [4:0] writeregw,
    input  logic       regwritee,
    input  logic       regwritem,
    input  logic       regwritew,
    input  logic       memtorege,
    input  logic       memtoregm,
    input  logic       branchd,
    input  logic       pcsrcd,
    input  logic       mdstartd,
    input  logic       mdopd,
    input  logic       mfhilod,
    output logic       forwardad,
    output logic       forwardbd,
    output logic [1:0] forwardae,
    output logic [1:0] forwardbe,
    output logic       stallf,
    output logic       stalld,
    output logic       flushd,
    output logic       flushe,
    output logic       mdbusy,
    output logic       hilo_we
);

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lwstall, branchstall, mdstall, stall;
    logic          rsd_nz, rtd_nz, rse_nz, rte_nz;

    assign rsd_nz = (rsd != 5'd0);
    assign rtd_nz = (rtd != 5'd0);
    assign rse_nz = (rse != 5'd0);
    assign rte_nz = (rte != 5'd0);

    // M-stage result is younger than W, so it wins when both match.
    always_comb begin
        forwardae = 2'b00;
        forwardbe = 2'b00;
        if (rse_nz && rse == writeregm && regwritem)      forwardae = 2'b10;
        else if (rse_nz && rse == writeregw && regwritew) forwardae = 2'b01;
        if (rte_nz && rte == writeregm && regwritem)      forwardbe = 2'b10;
        else if (rte_nz && rte == writeregw && regwritew) forwardbe = 2'b01;
    end

    assign forwardad = rsd_nz && (rsd == writeregm) && regwritem;
    assign forwardbd = rtd_nz && (rtd == writeregm) && regwritem;

    assign lwstall = memtorege && rte_nz && ((rte == rsd) || (rte == rtd));

    assign branchstall = branchd && (
        (regwritee && (writerege != 5'd0) && (writerege == rsd || writerege == rtd)) ||
        (memtoregm && (writeregm != 5'd0) && (writeregm == rsd || writeregm == rtd)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mdstartd && !lwstall && !branchstall) begin
                    state_d = BUSY;
                    cnt_d   = mdopd ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The strobe cycle still counts as busy, so an mfhi/mflo there waits one more cycle.
    assign mdbusy  = (state_q == BUSY);
    assign hilo_we = mdbusy && (cnt_q == '0);
    assign mdstall = mdbusy && (mdstartd || mfhilod);
    assign stall   = lwstall || branchstall || mdstall;

    assign stallf = stall;
    assign stalld = stall;
    assign flushe = stall;
    assign flushd = pcsrcd && !stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: the driver queues the expected output vector for each
// cycle it drives, and a negedge monitor pops and compares it against the DUT.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rsd, rtd, rse, rte, writerege, writeregm, writeregw;
    logic       regwritee, regwritem, regwritew, memtorege, memtoregm;
    logic       branchd, pcsrcd, mdstartd, mdopd, mfhilod;
    logic       forwardad, forwardbd, stallf, stalld, flushd, flushe, mdbusy, hilo_we;
    logic [1:0] forwardae, forwardbe;

    logic [11:0] exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CW(6)) dut (
        .clk(clk), .reset(reset),
        .rsd(rsd), .rtd(rtd), .rse(rse), .rte(rte),
        .writerege(writerege), .writeregm(writeregm), .writeregw(writeregw),
        .regwritee(regwritee), .regwritem(regwritem), .regwritew(regwritew),
        .memtorege(memtorege), .memtoregm(memtoregm),
        .branchd(branchd), .pcsrcd(pcsrcd),
        .mdstartd(mdstartd), .mdopd(mdopd), .mfhilod(mfhilod),
        .forwardad(forwardad), .forwardbd(forwardbd),
        .forwardae(forwardae), .forwardbe(forwardbe),
        .stallf(stallf), .stalld(stalld), .flushd(flushd), .flushe(flushe),
        .mdbusy(mdbusy), .hilo_we(hilo_we)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    // Packed as {fad, fbd, fae, fbe, stallf, stalld, flushd, flushe, mdbusy, hilo_we}
    function automatic logic [11:0] ex(input logic fad, input logic fbd,
                                       input logic [1:0] fae, input logic [1:0] fbe,
                                       input logic stl, input logic fld,
                                       input logic busy, input logic hwe);
        return {fad, fbd, fae, fbe, stl, stl, fld, stl, busy, hwe};
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [11:0] e, a;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {forwardad, forwardbd, forwardae, forwardbe, stallf, stalld,
                  flushd, flushe, mdbusy, hilo_we};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got %b expected %b", nm, a, e);
            end
        end
    end

    // Driver tasks
    task automatic clear_inputs();
        rsd = 0; rtd = 0; rse = 0; rte = 0;
        writerege = 0; writeregm = 0; writeregw = 0;
        regwritee = 0; regwritem = 0; regwritew = 0;
        memtorege = 0; memtoregm = 0;
        branchd = 0; pcsrcd = 0; mdstartd = 0; mdopd = 0; mfhilod = 0;
    endtask

    task automatic apply(input string nm, input logic [11:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        // mult/div requests during reset must not be accepted
        mdstartd = 1; mfhilod = 1;
        apply("reset_state", ex(0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        reset = 1'b0;
        clear_inputs();
        apply("post_reset_idle", ex(0, 0, 2'b00, 2'b00, 0, 0, 0, 0));

        // Forwarding
        regwritem = 1; writeregm = 8; regwritew = 1; writeregw = 8; rse = 8;
        apply("fwd_ae_m", ex(0, 0, 2'b10, 2'b00, 0, 0, 0, 0));
        regwritem = 0;
        apply("fwd_ae_w", ex(0, 0, 2'b01, 2'b00, 0, 0, 0, 0));
        regwritem = 1; writeregm = 0; rse = 0; rte = 8;
        apply("fwd_r0_and_be_w", ex(0, 0, 2'b00, 2'b01, 0, 0, 0, 0));
        writeregm = 8; rsd = 8; rte = 8;
        apply("fwd_ad_be_m", ex(1, 0, 2'b00, 2'b10, 0, 0, 0, 0));

        // Load-use
        clear_inputs();
        memtorege = 1; rte = 5; rsd = 5; pcsrcd = 1;
        apply("lwstall", ex(0, 0, 2'b00, 2'b00, 1, 0, 0, 0));
        memtorege = 0; pcsrcd = 0;
        apply("lwstall_clear", ex(0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        memtorege = 1; rte = 0; rsd = 0; rtd = 0;
        apply("lwstall_r0", ex(0, 0, 2'b00, 2'b00, 0, 0, 0, 0));

        // Branch
        clear_inputs();
        branchd = 1; regwritee = 1; writerege = 3; rtd = 3;
        apply("branchstall_e", ex(0, 0, 2'b00, 2'b00, 1, 0, 0, 0));
        regwritee = 0; writerege = 0; writeregm = 3; regwritem = 1; memtoregm = 0;
        pcsrcd = 1;
        apply("branch_fwd_bd", ex(0, 1, 2'b00, 2'b00, 0, 1, 0, 0));
        memtoregm = 1;
        apply("branchstall_m_load", ex(0, 1, 2'b00, 2'b00, 1, 0, 0, 0));

        // Mult held off by load-use, then accepted
        clear_inputs();
        mdstartd = 1; mdopd = 0; memtorege = 1; rte = 5; rsd = 5;
        apply("md_blocked_by_lw", ex(0, 0, 2'b00, 2'b00, 1, 0, 0, 0));
        memtorege = 0;
        apply("mult_accept", ex(0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        mdstartd = 0; mfhilod = 1;
        for (int k = 1; k <= 4; k++)
            apply($sformatf("mult_busy_t%0d", k), ex(0, 0, 2'b00, 2'b00, 1, 0, 1, k == 4));
        apply("mult_done_mfhi", ex(0, 0, 2'b00, 2'b00, 0, 0, 0, 0));

        // Div back-to-back with the second request held
        clear_inputs();
        mdstartd = 1; mdopd = 1;
        apply("div1_accept", ex(0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        for (int k = 1; k <= 32; k++)
            apply($sformatf("div1_busy_t%0d", k), ex(0, 0, 2'b00, 2'b00, 1, 0, 1, k == 32));
        apply("div2_accept", ex(0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        mdstartd = 0;
        for (int k = 1; k <= 32; k++)
            apply($sformatf("div2_busy_t%0d", k), ex(0, 0, 2'b00, 2'b00, 0, 0, 1, k == 32));
        apply("div2_done", ex(0, 0, 2'b00, 2'b00, 0, 0, 0, 0));

        // Reset mid-div
        mdstartd = 1; mdopd = 1;
        apply("div3_accept", ex(0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        mdstartd = 0; mfhilod = 1;
        for (int k = 1; k <= 9; k++)
            apply($sformatf("div3_busy_t%0d", k), ex(0, 0, 2'b00, 2'b00, 1, 0, 1, 0));
        reset = 1;
        apply("div3_reset_cycle", ex(0, 0, 2'b00, 2'b00, 1, 0, 1, 0));
        reset = 0;
        for (int k = 11; k <= 40; k++)
            apply($sformatf("div3_aborted_t%0d", k), ex(0, 0, 2'b00, 2'b00, 0, 0, 0, 0));

        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
